// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and default timing constants for the stopwatch controller
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, STOP = 2'd3} state_t;
    localparam int DEF_TICK_DIV = 1_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 250_000;
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: raw buttons in, counter/display controls out
interface stopwatch_if;
    import stopwatch_pkg::*;
    logic btn_start_stop;
    logic btn_lap;
    logic btn_reset;
    logic count_en;
    logic clear;
    logic hold;
    logic running;
    state_t state;
    modport master(output btn_start_stop, btn_lap, btn_reset, input count_en, clear, hold, running, state);
    modport slave(input btn_start_stop, btn_lap, btn_reset, output count_en, clear, hold, running, state);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: synchronizes, debounces and rising-edge detects one raw push button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic flip;
    // the level flips on the edge that takes the last of the required mismatching samples
    assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // sync chain, mismatch counter, stable level and registered press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? sync[1] : level;
            press <= flip && sync[1];
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/stop/lap FSM and count-tick prescaler
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic clk,
    input logic reset,
    stopwatch_if.slave sw
);
    localparam int PW = $clog2(TICK_DIV);
    logic p_ss, p_lap, p_rst;
    logic [2:0] lvl;
    state_t state_q, state_d;
    logic clear_d;
    logic [PW-1:0] presc;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk(clk), .reset(reset), .btn(sw.btn_start_stop), .level(lvl[0]), .press(p_ss)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk(clk), .reset(reset), .btn(sw.btn_lap), .level(lvl[1]), .press(p_lap)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
        .clk(clk), .reset(reset), .btn(sw.btn_reset), .level(lvl[2]), .press(p_rst)
    );

    assign sw.state    = state_q;
    assign sw.hold     = state_q == LAP;
    assign sw.running  = state_q == RUN || state_q == LAP;
    assign sw.count_en = sw.running && presc == PW'(TICK_DIV - 1);

    // next state with reset > start/stop > lap priority; reset only acts when stopped
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                clear_d = p_rst;
                state_d = (!p_rst && p_ss) ? RUN : IDLE;
            end
            RUN:  state_d = p_ss ? STOP : p_lap ? LAP : RUN;
            LAP:  state_d = p_ss ? STOP : p_lap ? RUN : LAP;
            STOP: begin
                clear_d = p_rst;
                state_d = p_rst ? IDLE : p_ss ? RUN : STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; clear sits high through reset so the datapath zeroes meanwhile
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sw.clear <= 1'b1;
        end else begin
            state_q  <= state_d;
            sw.clear <= clear_d;
        end
    end

    // prescaler advances while running, holds in STOP to keep the partial tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc <= '0;
        else if (sw.clear || state_q == IDLE) presc <= '0;
        else if (sw.running) presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button stimulus checked against a behavioural model
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;
    localparam int TD = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stopwatch_if sw();
    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (.clk(clk), .reset(reset), .sw(sw));

    int n_chk = 0;
    int n_ok = 0;
    int m_state, m_rc;
    bit m_clear;
    bit [15:0] hist [3];
    bit stab [3];
    bit prs [3];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rc = 0;
        m_clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hist[k] = '0;
            stab[k] = 1'b0;
            prs[k] = 1'b0;
        end
    endtask

    // one clock edge of the specified behaviour; b = {rst, lap, start_stop} raw levels
    task automatic model_edge(input logic [2:0] b);
        bit ps, pl, pr, all_diff;
        int ns;
        ps = prs[0];
        pl = prs[1];
        pr = prs[2];
        ns = m_state;
        m_clear = 1'b0;
        if (m_state == 0) begin
            if (pr) m_clear = 1'b1;
            else if (ps) ns = 1;
        end else if (m_state == 1) begin
            if (ps) ns = 3;
            else if (pl) ns = 2;
        end else if (m_state == 2) begin
            if (ps) ns = 3;
            else if (pl) ns = 1;
        end else begin
            if (pr) begin
                ns = 0;
                m_clear = 1'b1;
            end else if (ps) ns = 1;
        end
        m_state = ns;
        if (ns == 0) m_rc = 0;
        else if (ns == 1 || ns == 2) m_rc++;
        // a level changes once DB consecutive samples, seen two edges late, all disagree with it
        for (int k = 0; k < 3; k++) begin
            hist[k] = {hist[k][14:0], b[k]};
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) if (hist[k][j] == stab[k]) all_diff = 1'b0;
            prs[k] = 1'b0;
            if (all_diff) begin
                stab[k] = ~stab[k];
                prs[k] = stab[k];
            end
        end
    endtask

    task automatic check_outputs();
        bit run;
        run = (m_state == 1 || m_state == 2);
        chk("state", int'(sw.state), m_state);
        chk("clear", int'(sw.clear), int'(m_clear));
        chk("hold", int'(sw.hold), int'(m_state == 2));
        chk("running", int'(sw.running), int'(run));
        chk("count_en", int'(sw.count_en), int'(run && (m_rc % TD == 0)));
    endtask

    task automatic step(input logic [2:0] b);
        sw.btn_start_stop = b[0];
        sw.btn_lap = b[1];
        sw.btn_reset = b[2];
        @(posedge clk);
        model_edge(b);
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic hold_btn(input logic [2:0] b, input int n);
        repeat (n) step(b);
    endtask

    task automatic press(input logic [2:0] b);
        hold_btn(b, 6);
        hold_btn(3'b000, 8);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        sw.btn_start_stop = 1'b0;
        sw.btn_lap = 1'b0;
        sw.btn_reset = 1'b0;
        #1 model_reset();
        check_outputs();
        repeat (n) begin
            @(posedge clk);
            #1 check_outputs();
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        int lvl [3];
        int rem [3];
        sw.btn_start_stop = 1'b0;
        sw.btn_lap = 1'b0;
        sw.btn_reset = 1'b0;
        @(negedge clk);
        do_reset(5);
        step(3'b000);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step(3'b001);
            if (lat == 0 && sw.state == RUN) lat = i;
        end
        chk("start_latency", lat, DB + 3);
        hold_btn(3'b000, 14);
        step(3'b010);
        step(3'b000);
        step(3'b010);
        hold_btn(3'b000, 8);
        chk("bounce_state", int'(sw.state), 1);
        press(3'b010);
        chk("lap_hold", int'(sw.hold), 1);
        press(3'b010);
        chk("lap_release", int'(sw.hold), 0);
        press(3'b100);
        chk("rst_in_run", int'(sw.state), 1);
        press(3'b001);
        chk("stopped", int'(sw.state), 3);
        press(3'b001);
        press(3'b001);
        press(3'b101);
        chk("prio_rst_over_ss", int'(sw.state), 0);
        for (int k = 0; k < 3; k++) begin
            lvl[k] = 0;
            rem[k] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = (k == 2) ? int'($urandom_range(0, 3) == 0) : int'($urandom_range(0, 1));
                    rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(4, 12));
                end
                rem[k]--;
            end
            step({lvl[2][0], lvl[1][0], lvl[0][0]});
        end
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
